// File: rtl/beep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : beep_sequencer
//  Purpose  : Hourly chime / alarm buzzer sequencer with a tone generator.
//  Revision : 1.0 - initial release
// ============================================================================
module beep_sequencer #(
    parameter int TONE_DIV    = 1,
    parameter int ON_TICKS    = 200,
    parameter int OFF_TICKS   = 300,
    parameter int HOUR_MODE   = 1,
    parameter int FIXED_BEEPS = 3,
    parameter int ALARM_SEC   = 30
) (
    input  logic       clk_1khz,
    input  logic       switch_clr,
    input  logic       tick_1hz,
    input  logic       chime_req,
    input  logic [4:0] chime_hour,
    input  logic       alarm_hit,
    input  logic       alarm_en,
    input  logic       stop,
    output logic       beep,
    output logic       busy,
    output logic [1:0] mode
);

    localparam int c_MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int c_PW        = $clog2(c_MAX_TICKS + 1);
    localparam int c_TW        = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [c_PW-1:0] c_ON_LOAD    = c_PW'(ON_TICKS - 1);
    localparam logic [c_PW-1:0] c_OFF_LOAD   = c_PW'(OFF_TICKS - 1);
    localparam logic [c_PW-1:0] c_PHASE_ONE  = c_PW'(1);
    localparam logic [c_TW-1:0] c_TONE_LAST  = c_TW'(TONE_DIV - 1);
    localparam logic [c_TW-1:0] c_TONE_ONE   = c_TW'(1);
    localparam logic [5:0]      c_ALARM_LOAD = 6'(ALARM_SEC);
    localparam logic [3:0]      c_FIXED      = 4'(FIXED_BEEPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CH_ON  = 3'd1,
        S_CH_OFF = 3'd2,
        S_AL_ON  = 3'd3,
        S_AL_OFF = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_PW-1:0]   r_phase;
    logic [c_TW-1:0]   r_tdiv;
    logic              r_tone;
    logic [5:0]        r_sec;
    logic [3:0]        r_count;

    logic              w_in_al;
    logic              w_alarm_acc;
    logic              w_chime_acc;
    logic              w_load_phase;
    logic              w_next_on;
    logic [3:0]        w_hour_mod;
    logic [3:0]        w_hour_count;
    logic [3:0]        w_chime_count;

    // hour mod 12 with 0 shown as 12; only meaningful for hours 0..23
    assign w_hour_mod    = 4'((chime_hour >= 5'd12) ? (chime_hour - 5'd12) : chime_hour);
    assign w_hour_count  = (w_hour_mod == 4'd0) ? 4'd12 : w_hour_mod;
    assign w_chime_count = (HOUR_MODE != 0) ? w_hour_count : c_FIXED;

    always_comb begin
        w_next      = r_state;
        w_alarm_acc = 1'b0;
        w_chime_acc = 1'b0;
        w_in_al     = (r_state == S_AL_ON) || (r_state == S_AL_OFF);
        busy        = (r_state != S_IDLE);
        mode        = 2'b00;

        if (r_state == S_CH_ON || r_state == S_CH_OFF) begin
            mode = 2'b01;
        end else if (w_in_al) begin
            mode = 2'b10;
        end

        // stop outranks every other event, even an alarm hit in IDLE
        if (stop || (w_in_al && !alarm_en)) begin
            w_next = S_IDLE;
        end else if (alarm_hit && alarm_en) begin
            w_next      = S_AL_ON;
            w_alarm_acc = 1'b1;
        end else if (w_in_al && tick_1hz && (r_sec == 6'd1)) begin
            w_next = S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (chime_req && (chime_hour <= 5'd23)) begin
                w_next      = S_CH_ON;
                w_chime_acc = 1'b1;
            end
        end else if (r_phase == '0) begin
            case (r_state)
                S_CH_ON:  w_next = S_CH_OFF;
                S_CH_OFF: w_next = (r_count == 4'd0) ? S_IDLE : S_CH_ON;
                S_AL_ON:  w_next = S_AL_OFF;
                S_AL_OFF: w_next = S_AL_ON;
                default:  w_next = S_IDLE;
            endcase
        end

        w_load_phase = (w_next != r_state) || w_alarm_acc;
        w_next_on    = (w_next == S_CH_ON) || (w_next == S_AL_ON);
    end

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            r_phase <= '0;
        end else if (w_load_phase) begin
            case (w_next)
                S_CH_ON, S_AL_ON:   r_phase <= c_ON_LOAD;
                S_CH_OFF, S_AL_OFF: r_phase <= c_OFF_LOAD;
                default:            r_phase <= '0;
            endcase
        end else if (r_phase != '0) begin
            r_phase <= r_phase - c_PHASE_ONE;
        end
    end

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            r_count <= 4'd0;
        end else if (w_chime_acc) begin
            r_count <= w_chime_count;
        end else if (w_alarm_acc || (w_next == S_IDLE)) begin
            r_count <= 4'd0;
        end else if ((r_state == S_CH_ON) && (w_next == S_CH_OFF)) begin
            r_count <= r_count - 4'd1;
        end
    end

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            r_sec <= 6'd0;
        end else if (w_alarm_acc) begin
            r_sec <= c_ALARM_LOAD;
        end else if (w_next == S_IDLE) begin
            r_sec <= 6'd0;
        end else if (w_in_al && tick_1hz && (r_sec != 6'd0)) begin
            r_sec <= r_sec - 6'd1;
        end
    end

    // tone restarts low on every ON entry; beep is the registered tone
    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            r_tone <= 1'b0;
            r_tdiv <= '0;
        end else if (!w_next_on || w_load_phase) begin
            r_tone <= 1'b0;
            r_tdiv <= '0;
        end else if (r_tdiv == c_TONE_LAST) begin
            r_tone <= ~r_tone;
            r_tdiv <= '0;
        end else begin
            r_tdiv <= r_tdiv + c_TONE_ONE;
        end
    end

    assign beep = r_tone;

endmodule
`default_nettype wire

// File: tb/tb_beep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beep_sequencer
//  Purpose  : Self-checking bench for beep_sequencer (vector table + scenarios).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_beep_sequencer;

    logic       clk_1khz   = 1'b0;
    logic       switch_clr = 1'b1;
    logic       tick_1hz   = 1'b0;
    logic       chime_req  = 1'b0;
    logic [4:0] chime_hour = 5'd0;
    logic       alarm_hit  = 1'b0;
    logic       alarm_en   = 1'b0;
    logic       stop       = 1'b0;
    logic       beep, busy, beep2, busy2;
    logic [1:0] mode, mode2;

    int tests = 0;
    int fails = 0;

    always #5 clk_1khz = ~clk_1khz;

    beep_sequencer dut (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr), .tick_1hz(tick_1hz),
        .chime_req(chime_req), .chime_hour(chime_hour), .alarm_hit(alarm_hit),
        .alarm_en(alarm_en), .stop(stop), .beep(beep), .busy(busy), .mode(mode)
    );

    beep_sequencer #(.TONE_DIV(2)) dut2 (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr), .tick_1hz(tick_1hz),
        .chime_req(chime_req), .chime_hour(chime_hour), .alarm_hit(alarm_hit),
        .alarm_en(alarm_en), .stop(stop), .beep(beep2), .busy(busy2), .mode(mode2)
    );

    typedef struct {
        logic       chime;
        logic [4:0] hour;
        logic       hit;
        logic       en;
        logic       stp;
        logic       tick;
        logic [1:0] e_mode;
        logic       e_busy;
        logic       e_beep;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic       busy;
        logic       beep;
    } exp_t;

    vec_t vt[22];
    exp_t sb[$];
    exp_t e;

    int k, p, idx;
    int bad, bad2, blen, modebad, highs, highs_off, act_cnt;
    logic eb, eb2, b501;
    logic [1:0] m599, m600;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic clear_in();
        chime_req  = 1'b0;
        chime_hour = 5'd0;
        alarm_hit  = 1'b0;
        stop       = 1'b0;
        tick_1hz   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //        chime hour  hit en stp tick  mode  busy beep
        vt[0]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vt[10] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1};
        vt[11] = '{1'b1, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vt[12] = '{1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[13] = '{1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vt[14] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[15] = '{1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vt[16] = '{1'b1, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vt[17] = '{1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[18] = '{1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vt[19] = '{1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
        vt[20] = '{1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vt[21] = '{1'b1, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};

        // reset state
        step(); step(); step();
        check("reset.mode", 32'(mode), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.beep", 32'(beep), 32'd0);
        check("reset.beep2", 32'(beep2), 32'd0);
        switch_clr = 1'b0;
        step();

        // vector table through the scoreboard
        for (int i = 0; i < 22; i++) begin
            chime_req  = vt[i].chime;
            chime_hour = vt[i].hour;
            alarm_hit  = vt[i].hit;
            alarm_en   = vt[i].en;
            stop       = vt[i].stp;
            tick_1hz   = vt[i].tick;
            sb.push_back('{$sformatf("vec%0d", i), vt[i].e_mode, vt[i].e_busy, vt[i].e_beep});
            step();
            clear_in();
            e = sb.pop_front();
            check({e.name, ".mode"}, 32'(mode), 32'(e.mode));
            check({e.name, ".busy"}, 32'(busy), 32'(e.busy));
            check({e.name, ".beep"}, 32'(beep), 32'(e.beep));
        end
        alarm_en = 1'b0;
        step();

        // hour 15: three 200-cycle bursts, 300-cycle gaps, 1500 busy cycles
        chime_req = 1'b1; chime_hour = 5'd15;
        step(); clear_in();
        bad = 0; bad2 = 0; blen = 0; modebad = 0;
        for (k = 0; k < 1600; k++) begin
            p   = k % 500;
            eb  = (k < 1500 && p < 200) ? p[0] : 1'b0;
            eb2 = (k < 1500 && p < 200) ? p[1] : 1'b0;
            if (beep !== eb) bad++;
            if (beep2 !== eb2) bad2++;
            if (busy === 1'b1) blen++;
            if (k < 1500 && mode !== 2'b01) modebad++;
            if (k >= 1500 && mode !== 2'b00) modebad++;
            step();
        end
        check("chime15.busy_len", 32'(blen), 32'd1500);
        check("chime15.beep_pattern_errs", 32'(bad), 32'd0);
        check("chime15.div2_beep_errs", 32'(bad2), 32'd0);
        check("chime15.mode_errs", 32'(modebad), 32'd0);

        // midnight: 12 bursts, a second request mid-sequence is ignored
        chime_req = 1'b1; chime_hour = 5'd0;
        step(); clear_in();
        blen = 0; highs = 0;
        for (k = 0; k < 6100; k++) begin
            if (busy === 1'b1) blen++;
            if (beep === 1'b1) highs++;
            if (k == 650) begin
                chime_req = 1'b1; chime_hour = 5'd3;
            end
            step();
            clear_in();
        end
        check("midnight.busy_len", 32'(blen), 32'd6000);
        check("midnight.beep_highs", 32'(highs), 32'd1200);

        // alarm preempts the 2nd burst, times out after 30 ticks
        chime_req = 1'b1; chime_hour = 5'd15;
        step(); clear_in();
        for (k = 0; k < 600; k++) step();
        check("preempt.pre_mode", 32'(mode), 32'd1);
        alarm_en = 1'b1; alarm_hit = 1'b1;
        step(); clear_in();
        check("preempt.mode", 32'(mode), 32'd2);
        check("preempt.beep_entry", 32'(beep), 32'd0);
        highs = 0; highs_off = 0; b501 = 1'b0; m599 = 2'b11; m600 = 2'b11;
        for (int j = 0; j < 620; j++) begin
            tick_1hz = (j % 20 == 19);
            step();
            tick_1hz = 1'b0;
            idx = j + 1;
            if (idx <= 199 && beep === 1'b1) highs++;
            if (idx >= 200 && idx <= 499 && beep !== 1'b0) highs_off++;
            if (idx == 501) b501 = beep;
            if (idx == 599) m599 = mode;
            if (idx == 600) m600 = mode;
        end
        check("alarm.on_highs", 32'(highs), 32'd100);
        check("alarm.off_highs", 32'(highs_off), 32'd0);
        check("alarm.second_on_beep", 32'(b501), 32'd1);
        check("alarm.mode_before_timeout", 32'(m599), 32'd2);
        check("alarm.mode_at_timeout", 32'(m600), 32'd0);
        check("alarm.mode_after", 32'(mode), 32'd0);

        // stop during AL_OFF
        alarm_hit = 1'b1;
        step(); clear_in();
        for (k = 0; k < 250; k++) step();
        check("stop.pre_mode", 32'(mode), 32'd2);
        check("stop.pre_beep", 32'(beep), 32'd0);
        stop = 1'b1;
        step(); clear_in();
        check("stop.mode", 32'(mode), 32'd0);
        check("stop.busy", 32'(busy), 32'd0);

        // alarm_en dropped during AL_ON
        alarm_hit = 1'b1;
        step(); clear_in();
        for (k = 0; k < 11; k++) step();
        check("disable.pre_beep", 32'(beep), 32'd1);
        alarm_en = 1'b0;
        step();
        check("disable.mode", 32'(mode), 32'd0);
        check("disable.beep", 32'(beep), 32'd0);

        // reset mid-burst clears beep without a clock edge
        chime_req = 1'b1; chime_hour = 5'd2;
        step(); clear_in();
        step(); step(); step();
        check("rst.pre_beep", 32'(beep), 32'd1);
        #2 switch_clr = 1'b1;
        #1;
        check("rst.async_beep", 32'(beep), 32'd0);
        check("rst.async_busy", 32'(busy), 32'd0);
        check("rst.async_mode", 32'(mode), 32'd0);
        @(posedge clk_1khz); #1;
        switch_clr = 1'b0;
        act_cnt = 0;
        for (k = 0; k < 1000; k++) begin
            step();
            if (busy !== 1'b0 || beep !== 1'b0) act_cnt++;
        end
        check("rst.quiet_after_release", 32'(act_cnt), 32'd0);

        // first event after deassertion is accepted on the very next edge
        switch_clr = 1'b1;
        step();
        switch_clr = 1'b0;
        chime_req = 1'b1; chime_hour = 5'd1;
        step(); clear_in();
        check("rst.first_event_busy", 32'(busy), 32'd1);
        check("rst.first_event_mode", 32'(mode), 32'd1);
        stop = 1'b1;
        step(); clear_in();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
